// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the CPU's video-RAM slots between buffered CPU writes and
// (optionally) CPU reads.
//
// CPU strobes are asynchronous to CLK_50. Each strobe passes through two synchroniser
// flops and a third flop used for falling-edge detection. Writes go into a small FIFO.
// When the FIFO is full, a one-entry skid register holds the write and CPU_nWAIT is
// pulled low. Video timing pulses SLOT_STB when a RAM slot is free. The arbiter then
// owns the RAM for two cycles (SLOT1, SLOT2). FIFO writes always win. A read is issued
// only when nothing is queued ahead of it, so CPU program order is kept.
//
// Build option: define VRAM_ARB_READ_EN to enable the read path. Without it, CPU_nRD
// is ignored and CPU_DO is tied to zero.
//
// Parameters:
//   FIFO_DEPTH  buffered CPU writes (power of two, 2..16)
// Ports:
//   CLK_50      50 MHz clock, rising edge
//   nRESET      asynchronous active-low reset
//   CPU_A       CPU video-RAM address
//   CPU_DI      CPU write data
//   CPU_nWR     CPU write strobe, active-low, asynchronous
//   CPU_nRD     CPU read strobe, active-low, asynchronous
//   CPU_DO      data returned by the last completed read
//   CPU_nWAIT   wait request to the CPU, active-low
//   SLOT_STB    one-cycle pulse: a CPU RAM slot follows
//   ARB_VALID   arbiter owns the RAM this cycle
//   ARB_WR      owned slot is a write
//   ARB_A       slot address
//   ARB_WDATA   slot write data
//   ARB_RDATA   RAM read data, valid in the second slot cycle
//   FIFO_LEVEL  current write-FIFO occupancy
module vram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK_50,
  input  logic        nRESET,
  input  logic [14:0] CPU_A,
  input  logic [7:0]  CPU_DI,
  input  logic        CPU_nWR,
  input  logic        CPU_nRD,
  output logic [7:0]  CPU_DO,
  output logic        CPU_nWAIT,
  input  logic        SLOT_STB,
  output logic        ARB_VALID,
  output logic        ARB_WR,
  output logic [14:0] ARB_A,
  output logic [7:0]  ARB_WDATA,
  input  logic [7:0]  ARB_RDATA,
  output logic [4:0]  FIFO_LEVEL
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DepthLvl = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSlot1, StSlot2} state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Write strobe synchroniser and falling-edge detect.
  // Bits [0] and [1] form the synchroniser; bit [2] is the delayed copy used for the edge.
  // ---------------------------------------------------------------------------
  logic [2:0] wr_sync_q;
  logic       wr_fall;

  always_ff @(posedge CLK_50 or negedge nRESET) begin
    if (!nRESET) begin
      wr_sync_q <= 3'b111;
    end else begin
      wr_sync_q <= {wr_sync_q[1:0], CPU_nWR};
    end
  end

  assign wr_fall = wr_sync_q[2] & ~wr_sync_q[1];

  // ---------------------------------------------------------------------------
  // Write FIFO plus one-entry skid register
  // ---------------------------------------------------------------------------
  logic [14:0]     fifo_a_q [FIFO_DEPTH];
  logic [7:0]      fifo_d_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      level_q, level_d;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [14:0]     push_a;
  logic [7:0]      push_d;
  logic [14:0]     head_a;
  logic [7:0]      head_d;

  logic            skid_valid_q, skid_valid_d;
  logic [14:0]     skid_a_q, skid_a_d;
  logic [7:0]      skid_d_q, skid_d_d;

  assign fifo_full  = (level_q == DepthLvl);
  assign fifo_empty = (level_q == 5'd0);
  assign head_a     = fifo_a_q[rd_ptr_q];
  assign head_d     = fifo_d_q[rd_ptr_q];

  // The pop happens as the write slot leaves SLOT2. The head stays stable for the whole slot.
  assign pop = (state_q == StSlot2) && ARB_WR;

  // A parked skid entry drains before any new write can reach the FIFO. This keeps writes in order.
  always_comb begin
    push         = 1'b0;
    push_a       = skid_a_q;
    push_d       = skid_d_q;
    skid_valid_d = skid_valid_q;
    skid_a_d     = skid_a_q;
    skid_d_d     = skid_d_q;
    if (skid_valid_q) begin
      if (!fifo_full) begin
        push         = 1'b1;
        skid_valid_d = 1'b0;
        if (wr_fall) begin
          skid_valid_d = 1'b1;
          skid_a_d     = CPU_A;
          skid_d_d     = CPU_DI;
        end
      end
    end else if (wr_fall) begin
      if (fifo_full) begin
        skid_valid_d = 1'b1;
        skid_a_d     = CPU_A;
        skid_d_d     = CPU_DI;
      end else begin
        push   = 1'b1;
        push_a = CPU_A;
        push_d = CPU_DI;
      end
    end
  end

  assign level_d = level_q + {4'd0, push} - {4'd0, pop};

  always_ff @(posedge CLK_50 or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= 5'd0;
      skid_valid_q <= 1'b0;
      skid_a_q     <= 15'd0;
      skid_d_q     <= 8'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q      <= level_d;
      skid_valid_q <= skid_valid_d;
      skid_a_q     <= skid_a_d;
      skid_d_q     <= skid_d_d;
    end
  end

  // Storage needs no reset: reset clears the pointers and level, so old contents are unreachable.
  always_ff @(posedge CLK_50) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= push_a;
      fifo_d_q[wr_ptr_q] <= push_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic        rd_issue_ok;
  logic [14:0] rd_addr;

`ifdef VRAM_ARB_READ_EN
  logic [2:0]  rd_sync_q;
  logic        rd_fall;
  logic        rd_done;
  logic        rd_pending_q;
  logic        rd_release_q;
  logic [14:0] rd_addr_q;
  logic [7:0]  cpu_do_q;

  assign rd_fall = rd_sync_q[2] & ~rd_sync_q[1];
  assign rd_done = (state_q == StSlot2) && !ARB_WR;

  always_ff @(posedge CLK_50 or negedge nRESET) begin
    if (!nRESET) begin
      rd_sync_q    <= 3'b111;
      rd_pending_q <= 1'b0;
      rd_release_q <= 1'b0;
      rd_addr_q    <= 15'd0;
      cpu_do_q     <= 8'd0;
    end else begin
      rd_sync_q    <= {rd_sync_q[1:0], CPU_nRD};
      // Keeps CPU_nWAIT low for one extra cycle after CPU_DO loads.
      rd_release_q <= rd_done;
      if (rd_done) begin
        cpu_do_q     <= ARB_RDATA;
        rd_pending_q <= 1'b0;
      end else if (rd_fall && !rd_pending_q) begin
        rd_pending_q <= 1'b1;
        rd_addr_q    <= CPU_A;
      end
    end
  end

  // Any queued or parked write must reach the RAM before this read.
  assign rd_issue_ok = rd_pending_q && !skid_valid_q;
  assign rd_addr     = rd_addr_q;
  assign CPU_DO      = cpu_do_q;
  assign CPU_nWAIT   = ~(skid_valid_q | rd_pending_q | rd_release_q);
`else
  logic unused_rd;

  assign unused_rd   = ^{CPU_nRD, ARB_RDATA};
  assign rd_issue_ok = 1'b0;
  assign rd_addr     = 15'd0;
  assign CPU_DO      = 8'd0;
  assign CPU_nWAIT   = ~skid_valid_q;
`endif

  // ---------------------------------------------------------------------------
  // Slot state machine and registered RAM-side outputs
  // ---------------------------------------------------------------------------
  logic        arb_valid_q, arb_valid_d;
  logic        arb_wr_q, arb_wr_d;
  logic [14:0] arb_a_q, arb_a_d;
  logic [7:0]  arb_wdata_q, arb_wdata_d;

  always_comb begin
    state_d     = state_q;
    arb_valid_d = 1'b0;
    arb_wr_d    = arb_wr_q;
    arb_a_d     = arb_a_q;
    arb_wdata_d = arb_wdata_q;
    case (state_q)
      StIdle: begin
        if (SLOT_STB) begin
          if (!fifo_empty) begin
            state_d     = StSlot1;
            arb_valid_d = 1'b1;
            arb_wr_d    = 1'b1;
            arb_a_d     = head_a;
            arb_wdata_d = head_d;
          end else if (rd_issue_ok) begin
            state_d     = StSlot1;
            arb_valid_d = 1'b1;
            arb_wr_d    = 1'b0;
            arb_a_d     = rd_addr;
          end
        end
      end
      StSlot1: begin
        state_d     = StSlot2;
        arb_valid_d = 1'b1;
      end
      StSlot2: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK_50 or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= StIdle;
      arb_valid_q <= 1'b0;
      arb_wr_q    <= 1'b0;
      arb_a_q     <= 15'd0;
      arb_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      arb_valid_q <= arb_valid_d;
      arb_wr_q    <= arb_wr_d;
      arb_a_q     <= arb_a_d;
      arb_wdata_q <= arb_wdata_d;
    end
  end

  assign ARB_VALID  = arb_valid_q;
  assign ARB_WR     = arb_wr_q;
  assign ARB_A      = arb_a_q;
  assign ARB_WDATA  = arb_wdata_q;
  assign FIFO_LEVEL = level_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: self-checking bench for vram_arbiter (FIFO_DEPTH = 4).
// The stimulus pushes the expected RAM slots into a queue. A monitor compares each
// slot the DUT presents against the next queued entry and checks that every slot
// lasts exactly two cycles. Level, wait and reset behaviour are checked inline.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        nRESET = 1'b1;
  logic [14:0] CPU_A = '0;
  logic [7:0]  CPU_DI = '0;
  logic        CPU_nWR = 1'b1;
  logic        CPU_nRD = 1'b1;
  logic [7:0]  CPU_DO;
  logic        CPU_nWAIT;
  logic        SLOT_STB = 1'b0;
  logic        ARB_VALID;
  logic        ARB_WR;
  logic [14:0] ARB_A;
  logic [7:0]  ARB_WDATA;
  logic [7:0]  ARB_RDATA = 8'hA5;
  logic [4:0]  FIFO_LEVEL;

  vram_arbiter #(.FIFO_DEPTH(4)) dut (
    .CLK_50    (clk),
    .nRESET    (nRESET),
    .CPU_A     (CPU_A),
    .CPU_DI    (CPU_DI),
    .CPU_nWR   (CPU_nWR),
    .CPU_nRD   (CPU_nRD),
    .CPU_DO    (CPU_DO),
    .CPU_nWAIT (CPU_nWAIT),
    .SLOT_STB  (SLOT_STB),
    .ARB_VALID (ARB_VALID),
    .ARB_WR    (ARB_WR),
    .ARB_A     (ARB_A),
    .ARB_WDATA (ARB_WDATA),
    .ARB_RDATA (ARB_RDATA),
    .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [14:0] a;
    logic [7:0]  d;
  } slot_t;

  slot_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    slots_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to n clock edges later, then 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    slot_t s;
    s.wr = 1'b1;
    s.a = a;
    s.d = d;
    exp_q.push_back(s);
    CPU_A = a;
    CPU_DI = d;
    CPU_nWR = 1'b0;
    step(4);
    CPU_nWR = 1'b1;
    step(4);
  endtask

  task automatic pulse_stb(input int hold);
    SLOT_STB = 1'b1;
    step(hold);
    SLOT_STB = 1'b0;
  endtask

  // Monitor: each rising ARB_VALID starts a slot, which must match the queue head.
  initial begin
    slot_t cur;
    int    run;
    logic  prev_valid;
    cur = '0;
    run = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!nRESET) begin
        run = 0;
        prev_valid = 1'b0;
      end else begin
        if (ARB_VALID) begin
          if (!prev_valid) begin
            slots_seen++;
            run = 0;
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_slot: got slot wr=%0b a=0x%0h expected no slot",
                       ARB_WR, ARB_A);
              cur = '0;
            end else begin
              cur = exp_q.pop_front();
            end
          end
          run++;
          check("slot_wr", {31'd0, ARB_WR}, {31'd0, cur.wr});
          check("slot_a", {17'd0, ARB_A}, {17'd0, cur.a});
          if (cur.wr) check("slot_wdata", {24'd0, ARB_WDATA}, {24'd0, cur.d});
        end else if (prev_valid) begin
          check("slot_len", run, 2);
        end
        prev_valid = ARB_VALID;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_slots;
    // Reset values
    #2 nRESET = 1'b0;
    step(2);
    at_neg();
    check("rst_valid", {31'd0, ARB_VALID}, 0);
    check("rst_wr", {31'd0, ARB_WR}, 0);
    check("rst_a", {17'd0, ARB_A}, 0);
    check("rst_wdata", {24'd0, ARB_WDATA}, 0);
    check("rst_do", {24'd0, CPU_DO}, 0);
    check("rst_nwait", {31'd0, CPU_nWAIT}, 1);
    check("rst_level", {27'd0, FIFO_LEVEL}, 0);
    step(1);
    nRESET = 1'b1;
    step(2);

    // Single write, slot 10 cycles later
    cpu_write(15'h1234, 8'h5A);
    at_neg();
    check("w1_level", {27'd0, FIFO_LEVEL}, 1);
    step(10);
    pulse_stb(1);
    at_neg();
    check("w1_valid_c1", {31'd0, ARB_VALID}, 1);
    step(1);
    at_neg();
    check("w1_valid_c2", {31'd0, ARB_VALID}, 1);
    check("w1_level_mid", {27'd0, FIFO_LEVEL}, 1);
    step(1);
    at_neg();
    check("w1_valid_end", {31'd0, ARB_VALID}, 0);
    check("w1_level_end", {27'd0, FIFO_LEVEL}, 0);
    check("w1_a_hold", {17'd0, ARB_A}, 32'h1234);
    check("w1_wr_hold", {31'd0, ARB_WR}, 1);
    step(1);

    // Fill FIFO, fifth write lands in skid
    for (int i = 1; i <= 4; i++) cpu_write(15'h0010 + 15'(i), 8'h10 + 8'(i));
    at_neg();
    check("fill_level", {27'd0, FIFO_LEVEL}, 4);
    check("fill_nwait", {31'd0, CPU_nWAIT}, 1);
    step(1);
    cpu_write(15'h0015, 8'h15);
    at_neg();
    check("skid_level", {27'd0, FIFO_LEVEL}, 4);
    check("skid_nwait", {31'd0, CPU_nWAIT}, 0);
    step(1);
    pulse_stb(1);
    step(3);
    at_neg();
    check("skid_push_level", {27'd0, FIFO_LEVEL}, 4);
    check("skid_push_nwait", {31'd0, CPU_nWAIT}, 1);
    step(1);
    repeat (4) begin
      pulse_stb(1);
      step(3);
    end
    at_neg();
    check("drain_level", {27'd0, FIFO_LEVEL}, 0);
    step(1);

    // SLOT_STB held through SLOT1 and SLOT2 is ignored
    cpu_write(15'h2001, 8'h21);
    cpu_write(15'h2002, 8'h22);
    pulse_stb(3);
    at_neg();
    check("stb_ign_valid", {31'd0, ARB_VALID}, 0);
    check("stb_ign_level", {27'd0, FIFO_LEVEL}, 1);
    step(1);
    pulse_stb(1);
    step(3);
    at_neg();
    check("stb_ign_drain", {27'd0, FIFO_LEVEL}, 0);
    step(1);

    // Reset in SLOT1 with three writes queued
    cpu_write(15'h3001, 8'h31);
    cpu_write(15'h3002, 8'h32);
    cpu_write(15'h3003, 8'h33);
    at_neg();
    check("pre_rst_level", {27'd0, FIFO_LEVEL}, 3);
    step(1);
    pulse_stb(1);
    #4 nRESET = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, ARB_VALID}, 0);
    check("mid_rst_wr", {31'd0, ARB_WR}, 0);
    check("mid_rst_a", {17'd0, ARB_A}, 0);
    check("mid_rst_wdata", {24'd0, ARB_WDATA}, 0);
    check("mid_rst_do", {24'd0, CPU_DO}, 0);
    check("mid_rst_nwait", {31'd0, CPU_nWAIT}, 1);
    check("mid_rst_level", {27'd0, FIFO_LEVEL}, 0);
    exp_q.delete();
    step(2);
    nRESET = 1'b1;
    step(1);
    cpu_write(15'h4444, 8'h44);
    pulse_stb(1);
    step(3);
    at_neg();
    check("post_rst_level", {27'd0, FIFO_LEVEL}, 0);
    step(1);

`ifdef VRAM_ARB_READ_EN
    // Write then read of the same address: the write slot goes first
    begin
      slot_t r;
      cpu_write(15'h0100, 8'hA5);
      r.wr = 1'b0;
      r.a = 15'h0100;
      r.d = 8'h00;
      exp_q.push_back(r);
      CPU_A = 15'h0100;
      CPU_nRD = 1'b0;
      step(4);
      at_neg();
      check("rd_nwait_low", {31'd0, CPU_nWAIT}, 0);
      step(1);
      pulse_stb(1);
      step(3);
      at_neg();
      check("rd_nwait_after_w", {31'd0, CPU_nWAIT}, 0);
      step(1);
      pulse_stb(1);
      step(2);
      at_neg();
      check("rd_do", {24'd0, CPU_DO}, 32'hA5);
      check("rd_nwait_hold", {31'd0, CPU_nWAIT}, 0);
      step(1);
      at_neg();
      check("rd_nwait_rel", {31'd0, CPU_nWAIT}, 1);
      step(1);
      CPU_nRD = 1'b1;
      step(3);
      exp_slots = 11;
    end
`else
    // Reads disabled: CPU_nRD toggling must produce no slot and no wait
    for (int i = 0; i < 3; i++) begin
      CPU_A = 15'h0100 + 15'(i);
      CPU_nRD = 1'b0;
      step(5);
      at_neg();
      check("nord_nwait", {31'd0, CPU_nWAIT}, 1);
      check("nord_do", {24'd0, CPU_DO}, 0);
      step(1);
      pulse_stb(1);
      CPU_nRD = 1'b1;
      step(4);
    end
    exp_slots = 9;
`endif

    step(3);
    check("queue_drained", exp_q.size(), 0);
    check("slot_count", slots_seen, exp_slots);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered CPU writes (power of two, 2..16).
REQ-002 SHALL have port CLK_50 input 1: sole clock, 50 MHz, rising edge.
REQ-003 SHALL have port nRESET input 1: asynchronous, active-low reset.
REQ-004 SHALL have port CPU_A input 15: CPU video-RAM address.
REQ-005 SHALL have port CPU_DI input 8: CPU write data.
REQ-006 SHALL have port CPU_nWR input 1: CPU write strobe, active-low, asynchronous to CLK_50.
REQ-007 SHALL have port CPU_nRD input 1: CPU read strobe, active-low, asynchronous to CLK_50.
REQ-008 SHALL have port CPU_DO output 8: last read data.
REQ-009 SHALL have port CPU_nWAIT output 1: CPU wait request, active-low.
REQ-010 SHALL have port SLOT_STB input 1: one-cycle pulse from video timing; a CPU RAM slot follows.
REQ-011 SHALL have port ARB_VALID output 1: arbiter owns RAM this cycle.
REQ-012 SHALL have port ARB_WR output 1: owned slot is a write.
REQ-013 SHALL have port ARB_A output 15: slot address.
REQ-014 SHALL have port ARB_WDATA output 8: slot write data.
REQ-015 SHALL have port ARB_RDATA input 8: RAM read data, valid in the second slot cycle.
REQ-016 SHALL have port FIFO_LEVEL output 5: current write-FIFO occupancy.

Function
REQ-017 SHALL synchronise CPU_nWR and CPU_nRD through two flops each, then detect falling edges against a third registered copy.
REQ-018 SHALL, on a write falling edge, capture CPU_A and CPU_DI in the same cycle and push them into the FIFO; if the FIFO is full, SHALL hold them in a one-entry skid register and drive CPU_nWAIT low from the next cycle until the skid entry is pushed.
REQ-019 SHALL use a state machine with states IDLE, SLOT1, SLOT2; all ARB_* outputs registered.
REQ-020 IDLE: on SLOT_STB with work pending, SHALL enter SLOT1 next cycle with ARB_VALID=1, then SLOT2 (ARB_VALID=1, outputs held), then IDLE; SLOT_STB without work is ignored.
REQ-021 SHALL ignore SLOT_STB while in SLOT1 or SLOT2.
REQ-022 Priority: a FIFO write SHALL be issued whenever the FIFO is non-empty; a pending read SHALL be issued only when FIFO and skid are both empty, preserving CPU program order.
REQ-023 Write slot: ARB_WR=1, ARB_A/ARB_WDATA from FIFO head; pop SHALL occur on exit from SLOT2.
REQ-024 Read slot: ARB_WR=0, ARB_A = captured read address; CPU_DO SHALL load ARB_RDATA on the SLOT2 clock edge and hold until the next read completes.
REQ-025 On a read falling edge, SHALL capture CPU_A and drive CPU_nWAIT low from the next cycle until the cycle after CPU_DO is loaded.
REQ-026 Simultaneous push and pop SHALL leave FIFO_LEVEL unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 A new read edge while a read is pending SHALL be ignored.
REQ-028 ARB_A/ARB_WDATA/ARB_WR SHALL hold their last values when ARB_VALID=0.

Reset
REQ-029 While nRESET=0: ARB_VALID=0, ARB_WR=0, ARB_A=0, ARB_WDATA=0, CPU_DO=0, CPU_nWAIT=1, FIFO_LEVEL=0, skid empty, no read pending, state IDLE, synchroniser flops=1.
REQ-030 Reset mid-slot SHALL abort the slot immediately; queued writes are discarded.

Configuration
REQ-031 With VRAM_ARB_READ_EN defined, reads SHALL behave per REQ-022/024/025/027.
REQ-032 Without VRAM_ARB_READ_EN, CPU_nRD SHALL be ignored, CPU_DO SHALL be constant 0, and CPU_nWAIT SHALL depend only on REQ-018.

Verification
REQ-033 Single write A=0x1234 D=0x5A, SLOT_STB 10 cycles later -> ARB_VALID two cycles starting the cycle after SLOT_STB, ARB_WR=1, ARB_A=0x1234, ARB_WDATA=0x5A; FIFO_LEVEL 1->0.
REQ-034 Five writes, no SLOT_STB, FIFO_DEPTH=4 -> FIFO_LEVEL=4, CPU_nWAIT low after fifth; one slot -> skid pushed, FIFO_LEVEL=4, CPU_nWAIT high.
REQ-035 Write 0x0100<-0xA5 then read 0x0100, ARB_RDATA=0xA5 -> write slot precedes read slot, CPU_DO=0xA5, CPU_nWAIT released one cycle later.
REQ-036 SLOT_STB pulse during SLOT2 -> ignored, ARB_VALID exactly two cycles per issued slot.
REQ-037 nRESET low during SLOT1 with FIFO_LEVEL=3 -> all outputs at REQ-029 values within the same cycle.
REQ-038 Build without VRAM_ARB_READ_EN, toggle CPU_nRD -> no read slots, CPU_DO=0, CPU_nWAIT=1.
